ram_clear_sched: RTL and testbench
==================================

Name: ram_clear_sched

Overview:
- Scheduler that sequences the background clearing of SDRAM and DDR3 while the menu core runs.
- A single pacing token generator shares write-issue slots between the SDRAM channel and the DDRAM channel, round-robin.
- Tracks a per-channel address sweep, honours each port's busy handshake, and reports busy, done and progress to the top level.

Parameters:
- SD_AW, 25, SDRAM word address width.
- SD_LAST, 25'h1FFFFFF, last SDRAM address cleared (sweep runs 0..SD_LAST).
- DD_AW, 29, DDRAM 64-bit word address width.
- DD_BASE, 29'h0600_0000, first DDRAM address cleared.
- DD_WORDS, 29'h0200_0000, DDRAM words cleared; must be a multiple of DD_BURST.
- DD_BURST, 8, beats per DDRAM write burst (1..128).
- PACE, 32, clk_sys cycles per issue token (2..256).

Ports:
- clk_sys  in  1  system clock.
- RESET  in  1  synchronous, active-low; clock clk_sys.
- start  in  1  pulse; begins a sweep when idle.
- abort  in  1  pulse; stops the sweep.
- fill  in  16  fill word; used only with the optional feature.
- sd_busy  in  1  SDRAM controller not ready.
- sd_we  out  1  one-cycle SDRAM write strobe.
- sd_addr  out  SD_AW  SDRAM write address.
- sd_din  out  16  SDRAM write data.
- dd_busy  in  1  DDRAM waitrequest.
- dd_we  out  1  DDRAM write request.
- dd_addr  out  DD_AW  DDRAM burst start address.
- dd_burstcnt  out  8  DDRAM burst length, equal to DD_BURST.
- dd_din  out  64  DDRAM write data.
- dd_be  out  8  DDRAM byte enables, constant 8'hFF.
- busy  out  1  sweep in progress.
- done  out  1  last sweep completed.
- progress  out  8  {sd_addr top 4 bits, (dd_addr-DD_BASE) top 4 bits}.

Behaviour:
- Reset (RESET=0 at a clk_sys edge): FSM=IDLE; sd_we=0, dd_we=0; sd_addr=0; dd_addr=DD_BASE; busy=0; done=0; pacing counter=0; rr pointer=SDRAM. Reset mid-sweep abandons any burst immediately.
- FSM states:
  - IDLE: start=1 -> RUN. On entry to RUN: sd_addr=0, dd_addr=DD_BASE, pacing counter=0, done=0, busy=1.
  - RUN: both channels finished -> DONE. abort=1 -> ABORT.
  - ABORT: wait for any open DDRAM burst to finish -> IDLE. Exit leaves busy=0 and done=0.
  - DONE: set busy=0, done=1 -> IDLE. done stays 1 until the next start.
- start is ignored outside IDLE. abort is ignored in IDLE. When abort and start are asserted together in IDLE, start wins.
- Pacing:
  - Counter runs 0..PACE-1 in RUN only.
  - A token is generated in the cycle the counter equals PACE-1.
  - An unused token is dropped, never accumulated.
- Token grant:
  - A channel is eligible when it is unfinished and not busy. DDRAM must also have no open burst.
  - The token goes to the channel named by the rr pointer if eligible, else to the other channel if eligible.
  - After each grant the rr pointer moves to the non-granted channel.
- SDRAM channel:
  - A grant drives sd_we=1 for exactly one cycle with sd_addr stable.
  - sd_addr increments in the following cycle.
  - The write at SD_LAST marks the channel finished; sd_addr holds SD_LAST and does not wrap.
- DDRAM channel:
  - A grant raises dd_we, which stays high until DD_BURST beats are accepted. A beat is accepted when dd_we=1 and dd_busy=0.
  - dd_addr and dd_burstcnt stay constant throughout the burst.
  - After the last beat, dd_we drops and dd_addr advances by DD_BURST.
  - The channel is finished when dd_addr reaches DD_BASE+DD_WORDS.
  - A burst is never truncated, including on abort.
- Simultaneous finish of both channels in one cycle -> DONE in the next cycle.

Optional Feature:
- Macro RAM_CLEAR_FILL_EN.
- Defined: fill is latched at start. sd_din = latched fill; dd_din = {4{latched fill}}.
- Undefined: fill is unused; sd_din=0 and dd_din=0 (true clear).
- Ports exist in both builds.

Decomposition:
- Package ram_clear_pkg:
  - FSM state enum (IDLE, RUN, ABORT, DONE).
  - Channel index enum (CH_SD, CH_DD).
  - Localparam for the DDRAM byte-enable constant.
- One sub-module, ram_clear_token_arb: pacing counter plus round-robin token grant.

Test Plan:
All scenarios use SD_LAST=7, DD_BASE=0x100, DD_WORDS=16, DD_BURST=4, PACE=4.
- Reset then start, busys low:
  - 8 sd_we pulses, addresses 0..7.
  - 4 DDRAM bursts at 0x100, 0x104, 0x108, 0x10C.
  - Grants alternate SD/DD.
  - done=1, busy=0; sd_addr holds 7.
- dd_busy high for 10 cycles during the 2nd burst:
  - dd_we stays high and dd_addr stays 0x104 until 4 beats are accepted.
  - SDRAM tokens continue during the stall.
- sd_busy held high throughout: all tokens go to DDRAM; done stays 0 after DDRAM finishes. Releasing sd_busy -> SDRAM completes -> done=1.
- abort mid-burst after 2 beats: 2 more beats are issued, then IDLE with busy=0, done=0. A following start restarts at sd_addr=0, dd_addr=0x100.
- start pulsed during RUN: ignored, sweep order unchanged. RESET=0 mid-burst: next cycle dd_we=0, sd_we=0, and all outputs are at their reset values.
- RAM_CLEAR_FILL_EN with fill=16'hA5A5: every sd_din=16'hA5A5 and every dd_din=64'hA5A5A5A5A5A5A5A5. Without the macro, both are 0.

Source files
------------

// File: rtl/ram_clear_pkg.sv
// Shared types for the background RAM clear scheduler.
package ram_clear_pkg;

  typedef enum logic [1:0] {IDLE, RUN, ABORT, DONE} state_t;

  typedef enum logic {CH_SD, CH_DD} ch_t;

  // DDRAM writes always cover the full 64-bit word.
  localparam logic [7:0] DD_BE_ALL = 8'hFF;

endpackage

// File: rtl/ram_clear_token_arb.sv
// Pacing token generator and round-robin grant between SDRAM and DDRAM.
// One token every PACE cycles while run is high; unused tokens are dropped.
module ram_clear_token_arb
  import ram_clear_pkg::*;
#(
  parameter int PACE = 32
) (
  input  logic clk_sys,
  input  logic RESET,
  input  logic run,
  input  logic sd_ok,
  input  logic dd_ok,
  output logic gnt_sd,
  output logic gnt_dd
);

  localparam logic [7:0] CNT_LAST = 8'(PACE - 1);

  logic [7:0] cnt;
  ch_t        rr;
  logic       token;

  assign token = run && (cnt == CNT_LAST);

  // Preferred channel first, the other one only if the preferred cannot take it.
  always_comb begin
    gnt_sd = 1'b0;
    gnt_dd = 1'b0;
    if (token) begin
      if (rr == CH_SD) begin
        if (sd_ok)      gnt_sd = 1'b1;
        else if (dd_ok) gnt_dd = 1'b1;
      end else begin
        if (dd_ok)      gnt_dd = 1'b1;
        else if (sd_ok) gnt_sd = 1'b1;
      end
    end
  end

  // Pacing counter is held at zero outside a sweep so every sweep starts aligned.
  always_ff @(posedge clk_sys) begin
    if (!RESET) begin
      cnt <= '0;
      rr  <= CH_SD;
    end else begin
      if (!run || cnt == CNT_LAST) cnt <= '0;
      else                         cnt <= cnt + 8'd1;
      if (gnt_sd)      rr <= CH_DD;
      else if (gnt_dd) rr <= CH_SD;
    end
  end

endmodule

// File: rtl/ram_clear_sched.sv
// Background SDRAM / DDRAM clear scheduler.
// Build option RAM_CLEAR_FILL_EN: write the fill word latched at start
// instead of zero.
module ram_clear_sched
  import ram_clear_pkg::*;
#(
  parameter int               SD_AW    = 25,
  parameter logic [SD_AW-1:0] SD_LAST  = {SD_AW{1'b1}},
  parameter int               DD_AW    = 29,
  parameter logic [DD_AW-1:0] DD_BASE  = 29'h0600_0000,
  parameter logic [DD_AW-1:0] DD_WORDS = 29'h0200_0000,
  parameter int               DD_BURST = 8,
  parameter int               PACE     = 32
) (
  input  logic             clk_sys,
  input  logic             RESET,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      fill,
  input  logic             sd_busy,
  output logic             sd_we,
  output logic [SD_AW-1:0] sd_addr,
  output logic [15:0]      sd_din,
  input  logic             dd_busy,
  output logic             dd_we,
  output logic [DD_AW-1:0] dd_addr,
  output logic [7:0]       dd_burstcnt,
  output logic [63:0]      dd_din,
  output logic [7:0]       dd_be,
  output logic             busy,
  output logic             done,
  output logic [7:0]       progress
);

  localparam logic [DD_AW-1:0] DD_END     = DD_BASE + DD_WORDS;
  localparam logic [7:0]       BURST_LAST = 8'(DD_BURST - 1);

  state_t     state;
  logic       sd_fin;
  logic       dd_fin;
  logic [7:0] beat;
  logic       run;
  logic       sd_ok;
  logic       dd_ok;
  logic       gnt_sd;
  logic       gnt_dd;

  assign dd_fin = (dd_addr == DD_END);
  // No new grants in the abort cycle, so ABORT only has to drain an open burst.
  assign run    = (state == RUN) && !abort;
  assign sd_ok  = !sd_fin && !sd_busy;
  assign dd_ok  = !dd_fin && !dd_busy && !dd_we;

  ram_clear_token_arb #(.PACE(PACE)) u_arb (
    .clk_sys (clk_sys),
    .RESET   (RESET),
    .run     (run),
    .sd_ok   (sd_ok),
    .dd_ok   (dd_ok),
    .gnt_sd  (gnt_sd),
    .gnt_dd  (gnt_dd)
  );

  assign dd_burstcnt = 8'(DD_BURST);
  assign dd_be       = DD_BE_ALL;
  assign progress    = {sd_addr[SD_AW-1 -: 4], 4'((dd_addr - DD_BASE) >> (DD_AW - 4))};

  // Sweep FSM plus both channel datapaths; bursts run to completion in any state.
  always_ff @(posedge clk_sys) begin
    if (!RESET) begin
      state   <= IDLE;
      sd_we   <= 1'b0;
      dd_we   <= 1'b0;
      sd_addr <= '0;
      dd_addr <= DD_BASE;
      sd_fin  <= 1'b0;
      beat    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      sd_we <= gnt_sd;
      if (sd_we) begin
        if (sd_addr == SD_LAST) sd_fin  <= 1'b1;
        else                    sd_addr <= sd_addr + SD_AW'(1);
      end

      if (gnt_dd) begin
        dd_we <= 1'b1;
        beat  <= '0;
      end else if (dd_we && !dd_busy) begin
        beat <= beat + 8'd1;
        if (beat == BURST_LAST) begin
          dd_we   <= 1'b0;
          dd_addr <= dd_addr + DD_AW'(DD_BURST);
        end
      end

      case (state)
        IDLE: if (start) begin
          state   <= RUN;
          sd_addr <= '0;
          dd_addr <= DD_BASE;
          sd_fin  <= 1'b0;
          done    <= 1'b0;
          busy    <= 1'b1;
        end
        RUN: begin
          if (sd_fin && dd_fin) state <= DONE;
          else if (abort)       state <= ABORT;
        end
        ABORT: if (!dd_we) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RAM_CLEAR_FILL_EN
  logic [15:0] fill_q;

  // Pattern is captured once per sweep so it cannot change mid-sweep.
  always_ff @(posedge clk_sys) begin
    if (!RESET)                      fill_q <= '0;
    else if (state == IDLE && start) fill_q <= fill;
  end

  assign sd_din = fill_q;
  assign dd_din = {4{fill_q}};
`else
  logic unused_fill;
  assign unused_fill = ^fill;
  assign sd_din      = '0;
  assign dd_din      = '0;
`endif

endmodule

// File: tb/tb_ram_clear_sched.sv
// Directed bench for ram_clear_sched with a small sweep geometry.
module tb_ram_clear_sched;

  localparam logic [24:0] SD_LAST = 25'd7;
  localparam logic [28:0] DD_BASE = 29'h100;
`ifdef RAM_CLEAR_FILL_EN
  localparam logic [15:0] EXP_SD = 16'hA5A5;
`else
  localparam logic [15:0] EXP_SD = 16'h0000;
`endif
  localparam logic [63:0] EXP_DD = {4{EXP_SD}};

  logic        clk_sys = 1'b0;
  logic        RESET, start, abort, sd_busy, dd_busy;
  logic [15:0] fill;
  logic        sd_we, dd_we, busy, done;
  logic [24:0] sd_addr;
  logic [28:0] dd_addr;
  logic [15:0] sd_din;
  logic [63:0] dd_din;
  logic [7:0]  dd_burstcnt, dd_be, progress;

  ram_clear_sched #(
    .SD_LAST(SD_LAST), .DD_BASE(DD_BASE), .DD_WORDS(29'd16),
    .DD_BURST(4), .PACE(4)
  ) dut (
    .clk_sys(clk_sys), .RESET(RESET), .start(start), .abort(abort), .fill(fill),
    .sd_busy(sd_busy), .sd_we(sd_we), .sd_addr(sd_addr), .sd_din(sd_din),
    .dd_busy(dd_busy), .dd_we(dd_we), .dd_addr(dd_addr), .dd_burstcnt(dd_burstcnt),
    .dd_din(dd_din), .dd_be(dd_be), .busy(busy), .done(done), .progress(progress)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic        ch;    // 0 = SDRAM write, 1 = DDRAM burst start
    logic [28:0] addr;
  } wr_t;

  wr_t exp_tab [12];
  wr_t wlog [$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int n_ch(input logic ch);
    int n = 0;
    foreach (wlog[i]) if (wlog[i].ch == ch) n++;
    return n;
  endfunction

  // Write/burst monitor: logs issue order and checks per-write invariants.
  logic        prev_sd = 1'b0, prev_dd = 1'b0;
  int          beats = 0;
  logic [28:0] burst_addr = '0;
  always @(negedge clk_sys) begin
    if (!RESET) begin
      prev_sd = 1'b0;
      prev_dd = 1'b0;
    end else begin
      if (sd_we) begin
        chk("sd_we_one_cycle", 64'(prev_sd), 64'd0);
        chk("sd_din", 64'(sd_din), 64'(EXP_SD));
        wlog.push_back({1'b0, 29'(sd_addr)});
      end
      if (dd_we) begin
        if (!prev_dd) begin
          wlog.push_back({1'b1, dd_addr});
          burst_addr = dd_addr;
          beats = 0;
          chk("dd_burstcnt", 64'(dd_burstcnt), 64'd4);
          chk("dd_din", dd_din, EXP_DD);
          chk("dd_be", 64'(dd_be), 64'hFF);
        end else begin
          chk("dd_addr_stable", 64'(dd_addr), 64'(burst_addr));
        end
        if (!dd_busy) beats++;
      end else if (prev_dd) begin
        chk("dd_beats", 64'(beats), 64'd4);
      end
      prev_sd = sd_we;
      prev_dd = dd_we;
    end
  end

  task automatic do_reset();
    @(posedge clk_sys); #1;
    RESET = 1'b0; start = 1'b0; abort = 1'b0; sd_busy = 1'b0; dd_busy = 1'b0;
    @(posedge clk_sys); #1;
    RESET = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge clk_sys); #1 start = 1'b1;
    @(posedge clk_sys); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 500 && !done; i++) @(negedge clk_sys);
    chk(name, 64'(done), 64'd1);
  endtask

  task automatic compare_log(input string tag);
    chk({tag, "_count"}, 64'(wlog.size()), 64'd12);
    for (int i = 0; i < 12; i++) begin
      if (i < wlog.size()) begin
        chk($sformatf("%s_ch%0d", tag, i), 64'(wlog[i].ch), 64'(exp_tab[i].ch));
        chk($sformatf("%s_addr%0d", tag, i), 64'(wlog[i].addr), 64'(exp_tab[i].addr));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, sd_in_stall;
    logic found;

    // Alternating SD/DD while both are eligible, then SDRAM finishes alone.
    exp_tab[0]  = {1'b0, 29'd0};     exp_tab[1]  = {1'b1, 29'h100};
    exp_tab[2]  = {1'b0, 29'd1};     exp_tab[3]  = {1'b1, 29'h104};
    exp_tab[4]  = {1'b0, 29'd2};     exp_tab[5]  = {1'b1, 29'h108};
    exp_tab[6]  = {1'b0, 29'd3};     exp_tab[7]  = {1'b1, 29'h10C};
    exp_tab[8]  = {1'b0, 29'd4};     exp_tab[9]  = {1'b0, 29'd5};
    exp_tab[10] = {1'b0, 29'd6};     exp_tab[11] = {1'b0, 29'd7};

    RESET = 1'b0; start = 1'b0; abort = 1'b0; sd_busy = 1'b0; dd_busy = 1'b0;
    fill  = 16'hA5A5;

    // Reset state
    do_reset();
    @(negedge clk_sys);
    chk("rst_sd_we", 64'(sd_we), 64'd0);
    chk("rst_dd_we", 64'(dd_we), 64'd0);
    chk("rst_sd_addr", 64'(sd_addr), 64'd0);
    chk("rst_dd_addr", 64'(dd_addr), 64'h100);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_progress", 64'(progress), 64'd0);

    // Full sweep, no back-pressure
    wlog.delete();
    pulse_start();
    @(negedge clk_sys);
    chk("s1_busy_run", 64'(busy), 64'd1);
    wait_done("s1_done");
    chk("s1_busy_end", 64'(busy), 64'd0);
    chk("s1_sd_hold", 64'(sd_addr), 64'd7);
    chk("s1_dd_end", 64'(dd_addr), 64'h110);
    compare_log("s1");
    repeat (5) @(negedge clk_sys);
    chk("s1_done_sticky", 64'(done), 64'd1);
    @(posedge clk_sys); #1 abort = 1'b1;
    @(posedge clk_sys); #1 abort = 1'b0;
    @(negedge clk_sys);
    chk("idle_abort_done", 64'(done), 64'd1);
    chk("idle_abort_busy", 64'(busy), 64'd0);

    // DDRAM stall during the second burst
    do_reset();
    wlog.delete();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk_sys);
      if (dd_we && dd_addr == 29'h104) found = 1'b1;
    end
    chk("s2_burst2_seen", 64'(found), 64'd1);
    @(posedge clk_sys); #1 dd_busy = 1'b1;
    sd_in_stall = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_sys);
      chk("s2_stall_dd_we", 64'(dd_we), 64'd1);
      chk("s2_stall_dd_addr", 64'(dd_addr), 64'h104);
      if (sd_we) sd_in_stall++;
    end
    chk("s2_sd_during_stall", 64'(sd_in_stall >= 2), 64'd1);
    @(posedge clk_sys); #1 dd_busy = 1'b0;
    wait_done("s2_done");
    chk("s2_sd_count", 64'(n_ch(1'b0)), 64'd8);
    chk("s2_dd_count", 64'(n_ch(1'b1)), 64'd4);
    n = 0;
    foreach (wlog[i]) if (wlog[i].ch) begin
      chk("s2_dd_order", 64'(wlog[i].addr), 64'(29'h100 + 29'(4 * n)));
      n++;
    end

    // SDRAM busy throughout: DDRAM gets every token but done waits for SDRAM
    do_reset();
    wlog.delete();
    sd_busy = 1'b1;
    pulse_start();
    for (int i = 0; i < 300 && !(dd_addr == 29'h110 && !dd_we); i++) @(negedge clk_sys);
    chk("s3_dd_finished", 64'(dd_addr), 64'h110);
    repeat (20) @(negedge clk_sys);
    chk("s3_done_held", 64'(done), 64'd0);
    chk("s3_busy_held", 64'(busy), 64'd1);
    chk("s3_no_sd", 64'(n_ch(1'b0)), 64'd0);
    @(posedge clk_sys); #1 sd_busy = 1'b0;
    wait_done("s3_done");
    chk("s3_sd_count", 64'(n_ch(1'b0)), 64'd8);

    // Abort after two beats of the first burst: burst completes, then IDLE
    do_reset();
    wlog.delete();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk_sys);
      if (dd_we) found = 1'b1;
    end
    chk("s4_burst_seen", 64'(found), 64'd1);
    @(posedge clk_sys);
    @(posedge clk_sys); #1 abort = 1'b1;
    @(posedge clk_sys); #1 abort = 1'b0;
    for (int i = 0; i < 50 && busy; i++) @(negedge clk_sys);
    chk("s4_busy", 64'(busy), 64'd0);
    chk("s4_done", 64'(done), 64'd0);
    chk("s4_dd_we", 64'(dd_we), 64'd0);
    chk("s4_dd_addr", 64'(dd_addr), 64'h104);
    n = wlog.size();
    repeat (10) @(negedge clk_sys);
    chk("s4_quiet", 64'(wlog.size()), 64'(n));
    // start and abort together in IDLE: start wins
    @(posedge clk_sys); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk_sys); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk_sys);
    chk("s4_restart_busy", 64'(busy), 64'd1);
    chk("s4_restart_sd", 64'(sd_addr), 64'd0);
    chk("s4_restart_dd", 64'(dd_addr), 64'h100);
    wait_done("s4_done_after_restart");

    // start pulses during RUN are ignored
    do_reset();
    wlog.delete();
    pulse_start();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk_sys);
      if (done) break;
      start = (i % 9 == 5);
    end
    start = 1'b0;
    chk("s5_done", 64'(done), 64'd1);
    compare_log("s5");

    // Reset mid-burst
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk_sys);
      if (dd_we) found = 1'b1;
    end
    chk("s6_burst_seen", 64'(found), 64'd1);
    @(posedge clk_sys); #1 RESET = 1'b0;
    @(posedge clk_sys);
    @(negedge clk_sys);
    chk("s6_dd_we", 64'(dd_we), 64'd0);
    chk("s6_sd_we", 64'(sd_we), 64'd0);
    chk("s6_sd_addr", 64'(sd_addr), 64'd0);
    chk("s6_dd_addr", 64'(dd_addr), 64'h100);
    chk("s6_busy", 64'(busy), 64'd0);
    chk("s6_done", 64'(done), 64'd0);
    @(posedge clk_sys); #1 RESET = 1'b1;
    repeat (2) @(negedge clk_sys);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
